// File: rtl/normshift_iter_pkg.sv
// Shared configuration for the iterative normalization shifter: datapath
// and shift-amount widths as supplied by the FPU configuration record.
package normshift_iter_pkg;

  typedef struct packed {
    int NORMSHIFTSZ;
    int LOGNORMSHIFTSZ;
  } cvw_t;

  localparam cvw_t NORMSHIFT_CFG = '{NORMSHIFTSZ: 40, LOGNORMSHIFTSZ: 6};

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/normshift_iter_if.sv
// Operand and result channels of the normalization shifter.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the source holds its payload stable and valid
// high until that edge, and ready may depend combinationally on the sink state.
interface normshift_iter_if #(
  parameter int NSZ  = 40,
  parameter int LNSZ = 6,
  parameter int SBW  = 4
) ();
  logic            InValid;
  logic            InReady;
  logic [NSZ-1:0]  ShiftIn;
  logic [LNSZ-1:0] ShiftAmt;
  logic [SBW-1:0]  SideIn;
  logic            Flush;
  logic            OutValid;
  logic            OutReady;
  logic [NSZ-1:0]  Shifted;
  logic [SBW-1:0]  SideOut;

  modport master (
    output InValid, ShiftIn, ShiftAmt, SideIn, Flush, OutReady,
    input  InReady, OutValid, Shifted, SideOut
  );

  modport slave (
    input  InValid, ShiftIn, ShiftAmt, SideIn, Flush, OutReady,
    output InReady, OutValid, Shifted, SideOut
  );
endinterface

// File: rtl/normshift_iter_step.sv
// One radix-2^LOGSTEP left-shift step: shifts data by digit weighted by the
// step index; weights beyond the datapath width simply zero the result.
module normshift_step #(
  parameter int NSZ     = 40,
  parameter int LOGSTEP = 2,
  parameter int AW      = 6,
  parameter int CW      = 2
) (
  input  logic [NSZ-1:0]     data_i,
  input  logic [LOGSTEP-1:0] digit_i,
  input  logic [CW-1:0]      index_i,
  output logic [NSZ-1:0]     data_o
);
  logic [AW-1:0] shamt;

  assign shamt  = AW'(digit_i) << (int'(index_i) * LOGSTEP);
  assign data_o = data_i << shamt;
endmodule

// File: rtl/normshift_iter.sv
// Multi-cycle normalization shifter: resolves LOGSTEP bits of the shift
// amount per cycle through one reused step, with a fixed NSTEP-cycle latency.
module normshift_iter
  import normshift_iter_pkg::*;
#(
  parameter cvw_t P       = NORMSHIFT_CFG,
  parameter int   LOGSTEP = 2,
  parameter int   SBW     = 4
) (
  input  logic               clk,
  input  logic               reset,
  normshift_iter_if.slave    io,
  output logic [1:0]         dbg_state
);
  localparam int NSZ   = P.NORMSHIFTSZ;
  localparam int LNSZ  = P.LOGNORMSHIFTSZ;
  localparam int NSTEP = ceil_div(LNSZ, LOGSTEP);
  localparam int AW    = NSTEP * LOGSTEP;
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [NSZ-1:0] data_q, data_d, step_data;
  logic [AW-1:0]  amt_q, amt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SBW-1:0] side_q, side_d;
  logic           accept, last_step;

  // The amount register is consumed low digit first, so the step always
  // reads its bottom LOGSTEP bits while the index supplies the weight.
  normshift_step #(.NSZ(NSZ), .LOGSTEP(LOGSTEP), .AW(AW), .CW(CW)) u_step (
    .data_i  (data_q),
    .digit_i (amt_q[LOGSTEP-1:0]),
    .index_i (cnt_q),
    .data_o  (step_data)
  );

  assign io.InReady = reset & ~io.Flush &
                      ((state_q == IDLE) | ((state_q == DONE) & io.OutReady));
  assign accept     = io.InValid & io.InReady;
  assign last_step  = (cnt_q == CW'(NSTEP - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    side_d  = side_q;
    case (state_q)
      IDLE: ;
      SHIFT: begin
        data_d = step_data;
        amt_d  = amt_q >> LOGSTEP;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: if (io.OutReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      data_d  = io.ShiftIn;
      amt_d   = AW'(io.ShiftAmt);
      side_d  = io.SideIn;
      cnt_d   = '0;
      state_d = SHIFT;
    end
    // Flush wins over both a new accept and a completing step.
    if (io.Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      side_q  <= side_d;
    end
  end

  assign io.OutValid = (state_q == DONE);
  assign io.Shifted  = data_q;
  assign io.SideOut  = side_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_normshift_iter.sv
// Self-checking bench for normshift_iter: directed latency/backpressure/flush/
// reset scenarios plus a random run checked against a plain shift reference.
module tb_normshift_iter;
  import normshift_iter_pkg::*;

  localparam cvw_t CFG     = NORMSHIFT_CFG;
  localparam int   NSZ     = CFG.NORMSHIFTSZ;
  localparam int   LNSZ    = CFG.LOGNORMSHIFTSZ;
  localparam int   LOGSTEP = 2;
  localparam int   SBW     = 4;
  localparam int   NSTEP   = (LNSZ + LOGSTEP - 1) / LOGSTEP;
  localparam int   W       = SBW + NSZ;
  localparam int   NRAND   = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;
  int         total = 0, bad = 0, n_push = 0, n_pop = 0;
  logic [W-1:0] exp_q[$];

  normshift_iter_if #(.NSZ(NSZ), .LNSZ(LNSZ), .SBW(SBW)) io ();

  normshift_iter #(.P(CFG), .LOGSTEP(LOGSTEP), .SBW(SBW)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (io),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [NSZ-1:0] din,
                                           input logic [LNSZ-1:0] amt,
                                           input logic [SBW-1:0] side);
    logic [NSZ-1:0] s;
    s = din << amt;
    return {side, s};
  endfunction

  // Scoreboard: every completed output transfer pops one expected result.
  always @(negedge clk) begin
    if (reset && io.OutValid && io.OutReady) begin
      n_pop++;
      chk("out_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("result", {io.SideOut, io.Shifted}, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [NSZ-1:0] din, input logic [LNSZ-1:0] amt,
                      input logic [SBW-1:0] side, input bit push, output int waits);
    io.InValid  = 1'b1;
    io.ShiftIn  = din;
    io.ShiftAmt = amt;
    io.SideIn   = side;
    for (waits = 0; waits < 200; waits++) begin
      @(negedge clk);
      if (io.InReady) break;
    end
    chk("accept", io.InReady, 1'b1);
    if (push && io.InReady) begin
      exp_q.push_back(ref_res(din, amt, side));
      n_push++;
    end
    @(posedge clk);
    #1;
    io.InValid = 1'b0;
  endtask

  // Counts rising edges after the accept until OutValid is seen.
  task automatic wait_out(output int c);
    c = 0;
    while (c < 50) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (io.OutValid) break;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int          w, c, v;
  logic [W-1:0] held;
  logic [63:0] r;
  bit          done;

  initial begin
    io.InValid  = 1'b0;
    io.ShiftIn  = '0;
    io.ShiftAmt = '0;
    io.SideIn   = '0;
    io.Flush    = 1'b0;
    io.OutReady = 1'b1;
    done        = 1'b0;

    #3;
    chk("rst_in_ready", io.InReady, 1'b0);
    chk("rst_out_valid", io.OutValid, 1'b0);
    chk("rst_shifted", io.Shifted, 64'd0);
    chk("rst_side", io.SideOut, 64'd0);
    chk("rst_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Basic shift with exact latency, then return to idle.
    send(NSZ'(1), LNSZ'(5), 4'hA, 1'b1, w);
    wait_out(c);
    chk("t1_latency", c, NSTEP);
    chk("t1_shifted", io.Shifted, 64'd32);
    chk("t1_side", io.SideOut, 64'hA);
    @(negedge clk);
    chk("t1_idle_state", dbg_state, 2'd0);
    chk("t1_idle_ready", io.InReady, 1'b1);

    // Boundary amounts: width-1 keeps only the MSB, all-ones amount clears.
    next_cycle();
    send('1, LNSZ'(NSZ - 1), 4'h3, 1'b1, w);
    wait_out(c);
    chk("t2_msb_only", io.Shifted, 64'd1 << (NSZ - 1));
    next_cycle();
    send('1, '1, 4'h4, 1'b1, w);
    wait_out(c);
    chk("t2_overshift", io.Shifted, 64'd0);

    // Backpressure hold, then back-to-back accept on release.
    next_cycle();
    io.OutReady = 1'b0;
    send(NSZ'(64'h1234_5678), LNSZ'(7), 4'h5, 1'b1, w);
    wait_out(c);
    held = {io.SideOut, io.Shifted};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t3_hold", {io.SideOut, io.Shifted}, held);
      chk("t3_valid_held", io.OutValid, 1'b1);
      chk("t3_no_ready", io.InReady, 1'b0);
    end
    next_cycle();
    io.OutReady = 1'b1;
    send(NSZ'(3), LNSZ'(0), 4'h6, 1'b1, w);
    chk("t3_same_cycle_accept", w, 0);
    wait_out(c);
    chk("t3_latency", c, NSTEP);
    chk("t3_shifted", io.Shifted, 64'd3);

    // Flush during SHIFT discards the operand.
    next_cycle();
    send(NSZ'(1), LNSZ'(2), 4'h7, 1'b0, w);
    next_cycle();
    io.Flush = 1'b1;
    @(negedge clk);
    chk("t4_flush_blocks_ready", io.InReady, 1'b0);
    next_cycle();
    io.Flush = 1'b0;
    @(negedge clk);
    chk("t4_flush_idle", dbg_state, 2'd0);
    v = 0;
    repeat (8) begin
      @(negedge clk);
      v += int'(io.OutValid);
    end
    chk("t4_no_output", v, 0);
    next_cycle();
    send(NSZ'(1), LNSZ'(3), 4'h1, 1'b1, w);
    wait_out(c);
    chk("t4_after_flush", io.Shifted, 64'd8);

    // Asynchronous reset in the middle of SHIFT.
    next_cycle();
    send(NSZ'(5), LNSZ'(4), 4'hF, 1'b0, w);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", io.OutValid, 1'b0);
    chk("t5_rst_ready", io.InReady, 1'b0);
    chk("t5_rst_shifted", io.Shifted, 64'd0);
    chk("t5_rst_side", io.SideOut, 64'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", io.InReady, 1'b1);
    v = 0;
    repeat (8) begin
      @(negedge clk);
      v += int'(io.OutValid);
    end
    chk("t5_no_stale", v, 0);

    // Random operands with random downstream stalls.
    next_cycle();
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) next_cycle();
          r = {$urandom(), $urandom()};
          send(r[NSZ-1:0], LNSZ'($urandom_range(0, (1 << LNSZ) - 1)),
               SBW'($urandom_range(0, (1 << SBW) - 1)), 1'b1, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          next_cycle();
          io.OutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    io.OutReady = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("out_count", n_pop, n_push);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
